// File: rtl/rotary_menu_ctrl.sv
// Three-level rotary menu (idle / field select / value edit) owning NUM_FIELDS
// saturating parameter registers with speed-accelerated stepping and change strobes.
module rotary_menu_ctrl #(
    parameter int unsigned NUM_FIELDS     = 4,
    parameter int unsigned FIELD_W        = 8,
    parameter int unsigned INIT_VAL       = 0,
    parameter int unsigned ACCEL_WINDOW   = 50000,
    parameter int unsigned ACCEL_STEP     = 4,
    parameter int unsigned TIMEOUT_CYCLES = 5000000,
    localparam int unsigned SEL_W         = $clog2(NUM_FIELDS)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          rot_cw,
    input  logic                          rot_ccw,
    input  logic                          btn_press,
    output logic [1:0]                    menu_state,
    output logic [SEL_W-1:0]              field_sel,
    output logic [NUM_FIELDS*FIELD_W-1:0] field_vals,
    output logic                          update_valid,
    output logic [SEL_W-1:0]              update_idx
);

    localparam int unsigned ACC_W  = $clog2(ACCEL_WINDOW + 1);
    localparam int unsigned TO_W   = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned VALS_W = NUM_FIELDS * FIELD_W;
    localparam int unsigned VW     = FIELD_W + 1;
    localparam logic [VW-1:0] VAL_MAX = {1'b0, {FIELD_W{1'b1}}};

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SELECT = 2'd1,
        ST_EDIT   = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [SEL_W-1:0]   sel_d;
    logic [VALS_W-1:0]  vals_d;
    logic               upd_valid_d;
    logic [SEL_W-1:0]   upd_idx_d;
    logic [ACC_W-1:0]   accel_q, accel_d;
    logic               last_cw_q, last_cw_d;
    logic [TO_W-1:0]    to_q, to_d;

    logic               rot_evt, act, go_cw, go_ccw, timed_out;
    logic [FIELD_W-1:0] cur_val, new_val;
    logic [VW-1:0]      step, sum, diff;

    assign menu_state = state_q;

    // Event qualification, step selection and saturating value arithmetic
    always_comb begin
        rot_evt   = rot_cw ^ rot_ccw;
        act       = btn_press | rot_evt;
        go_cw     = rot_evt & ~btn_press & rot_cw;
        go_ccw    = rot_evt & ~btn_press & rot_ccw;
        timed_out = (to_q == TO_W'(TIMEOUT_CYCLES));
        cur_val   = field_vals[32'(field_sel) * FIELD_W +: FIELD_W];
        step      = ((accel_q < ACC_W'(ACCEL_WINDOW)) && (rot_cw == last_cw_q))
                    ? VW'(ACCEL_STEP) : VW'(1);
        sum       = {1'b0, cur_val} + step;
        diff      = {1'b0, cur_val} - step;
        new_val   = cur_val;
        if (go_cw) begin
            new_val = (sum > VAL_MAX) ? '1 : sum[FIELD_W-1:0];
        end else if (go_ccw) begin
            new_val = diff[FIELD_W] ? '0 : diff[FIELD_W-1:0];
        end
    end

    // Next-state and register updates
    always_comb begin
        state_d     = state_q;
        sel_d       = field_sel;
        vals_d      = field_vals;
        upd_valid_d = 1'b0;
        upd_idx_d   = update_idx;
        last_cw_d   = last_cw_q;
        accel_d     = (accel_q == ACC_W'(ACCEL_WINDOW)) ? accel_q : accel_q + ACC_W'(1);
        to_d        = (state_q == ST_IDLE) ? '0 : to_q + TO_W'(1);
        if (act) begin
            to_d = '0;
        end

        case (state_q)
            ST_IDLE: begin
                if (act) begin
                    state_d = ST_SELECT;
                end
            end
            ST_SELECT: begin
                if (btn_press) begin
                    state_d = ST_EDIT;
                    accel_d = ACC_W'(ACCEL_WINDOW);
                end else if (go_cw) begin
                    sel_d = (field_sel == SEL_W'(NUM_FIELDS - 1)) ? '0 : field_sel + SEL_W'(1);
                end else if (go_ccw) begin
                    sel_d = (field_sel == '0) ? SEL_W'(NUM_FIELDS - 1) : field_sel - SEL_W'(1);
                end else if (timed_out) begin
                    state_d = ST_IDLE;
                    to_d    = '0;
                end
            end
            ST_EDIT: begin
                if (btn_press) begin
                    state_d = ST_SELECT;
                end else if (go_cw || go_ccw) begin
                    accel_d   = '0;
                    last_cw_d = rot_cw;
                    vals_d[32'(field_sel) * FIELD_W +: FIELD_W] = new_val;
                    if (new_val != cur_val) begin
                        upd_valid_d = 1'b1;
                        upd_idx_d   = field_sel;
                    end
                end else if (timed_out) begin
                    state_d = ST_IDLE;
                    to_d    = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            field_sel    <= '0;
            field_vals   <= {NUM_FIELDS{FIELD_W'(INIT_VAL)}};
            update_valid <= 1'b0;
            update_idx   <= '0;
            accel_q      <= ACC_W'(ACCEL_WINDOW);
            last_cw_q    <= 1'b1;
            to_q         <= '0;
        end else begin
            state_q      <= state_d;
            field_sel    <= sel_d;
            field_vals   <= vals_d;
            update_valid <= upd_valid_d;
            update_idx   <= upd_idx_d;
            accel_q      <= accel_d;
            last_cw_q    <= last_cw_d;
            to_q         <= to_d;
        end
    end

endmodule

// File: tb/tb_rotary_menu_ctrl.sv
// Bench for rotary_menu_ctrl: timestamp-based menu model compared every cycle,
// plus directed rotary sequences with hand-computed expectations.
module tb_rotary_menu_ctrl;

    localparam int NF   = 4;
    localparam int FW   = 8;
    localparam int INIT = 10;
    localparam int WIN  = 8;
    localparam int ASTP = 4;
    localparam int TO   = 100;

    logic          clk = 1'b0;
    logic          rst;
    logic          rot_cw, rot_ccw, btn_press;
    logic [1:0]    menu_state;
    logic [1:0]    field_sel;
    logic [NF*FW-1:0] field_vals;
    logic          update_valid;
    logic [1:0]    update_idx;

    int checks   = 0;
    int failures = 0;
    int strobes  = 0;
    bit started  = 1'b0;

    // Model state: timestamps of last activity/edit instead of counters
    int     m_state;
    int     m_sel;
    int     m_vals [NF];
    bit     m_upd;
    int     m_idx;
    bit     m_last_cw;
    longint m_n, m_last_act, m_last_edit;

    rotary_menu_ctrl #(
        .NUM_FIELDS(NF), .FIELD_W(FW), .INIT_VAL(INIT),
        .ACCEL_WINDOW(WIN), .ACCEL_STEP(ASTP), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .rst(rst), .rot_cw(rot_cw), .rot_ccw(rot_ccw),
        .btn_press(btn_press), .menu_state(menu_state), .field_sel(field_sel),
        .field_vals(field_vals), .update_valid(update_valid), .update_idx(update_idx)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int fv(input int i);
        logic [NF*FW-1:0] v;
        v = field_vals;
        return int'(v[i*FW +: FW]);
    endfunction

    task automatic pulse(input bit cw, input bit ccw, input bit btn);
        @(negedge clk);
        rot_cw = cw; rot_ccw = ccw; btn_press = btn;
        @(negedge clk);
        rot_cw = 1'b0; rot_ccw = 1'b0; btn_press = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Behavioural model, advanced on each sampling edge
    initial begin
        bit cw, ccw, btn, act, rot, accel;
        int v, nv, step;
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                m_state = 0; m_sel = 0; m_upd = 1'b0; m_idx = 0; m_last_cw = 1'b1;
                m_last_act = 0; m_last_edit = -1000000;
                for (int i = 0; i < NF; i++) m_vals[i] = INIT;
            end else begin
                m_n++;
                cw = rot_cw; ccw = rot_ccw; btn = btn_press;
                act = btn || (cw != ccw);
                rot = (cw != ccw) && !btn;
                m_upd = 1'b0;
                if (act) m_last_act = m_n;
                case (m_state)
                    0: if (act) m_state = 1;
                    1: begin
                        if (btn) begin
                            m_state = 2;
                            m_last_edit = -1000000;
                        end else if (rot) begin
                            m_sel = cw ? (m_sel + 1) % NF : (m_sel + NF - 1) % NF;
                        end else if (m_n - m_last_act > TO) begin
                            m_state = 0;
                        end
                    end
                    default: begin
                        if (btn) begin
                            m_state = 1;
                        end else if (rot) begin
                            v = m_vals[m_sel];
                            accel = (m_n - m_last_edit <= WIN) && (cw == m_last_cw);
                            step = accel ? ASTP : 1;
                            nv = cw ? v + step : v - step;
                            if (nv > (1 << FW) - 1) nv = (1 << FW) - 1;
                            if (nv < 0) nv = 0;
                            if (nv != v) begin
                                m_upd = 1'b1;
                                m_idx = m_sel;
                            end
                            m_vals[m_sel] = nv;
                            m_last_edit = m_n;
                            m_last_cw = cw;
                        end else if (m_n - m_last_act > TO) begin
                            m_state = 0;
                        end
                    end
                endcase
            end
        end
    end

    // Every-cycle comparison against the model
    initial begin
        logic [NF*FW-1:0] e;
        forever begin
            @(negedge clk);
            if (started && !rst) begin
                for (int i = 0; i < NF; i++) e[i*FW +: FW] = FW'(m_vals[i]);
                chk("cyc_state", menu_state, m_state);
                chk("cyc_sel", field_sel, m_sel);
                chk("cyc_vals", field_vals, e);
                chk("cyc_upd_valid", update_valid, m_upd);
                if (m_upd) chk("cyc_upd_idx", update_idx, m_idx);
                if (update_valid) strobes++;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int s0;
        rst = 1'b1; rot_cw = 1'b0; rot_ccw = 1'b0; btn_press = 1'b0;
        idle(3);
        rst = 1'b0;
        started = 1'b1;
        idle(1);
        chk("rst_state", menu_state, 0);
        chk("rst_sel", field_sel, 0);
        chk("rst_upd", update_valid, 0);
        for (int i = 0; i < NF; i++) chk("rst_field", fv(i), INIT);

        // Field select navigation with wrap
        pulse(0, 0, 1); chk("t1_select", menu_state, 1); chk("t1_sel0", field_sel, 0);
        idle(18); pulse(1, 0, 0); chk("t1_sel1", field_sel, 1);
        idle(18); pulse(1, 0, 0); chk("t1_sel2", field_sel, 2);
        idle(18); pulse(1, 0, 0); chk("t1_sel3", field_sel, 3);
        idle(18); pulse(0, 1, 0); chk("t1_sel_back2", field_sel, 2);
        idle(18); pulse(1, 0, 0); chk("t1_sel3b", field_sel, 3);
        idle(18); pulse(1, 0, 0); chk("t1_wrap0", field_sel, 0);

        // Slow edits on field 2
        pulse(0, 1, 0); chk("t2_wrap3", field_sel, 3);
        pulse(0, 1, 0); chk("t2_sel2", field_sel, 2);
        pulse(0, 0, 1); chk("t2_edit", menu_state, 2);
        idle(18); pulse(1, 0, 0);
        chk("t2_v11", fv(2), 11); chk("t2_upd", update_valid, 1); chk("t2_idx", update_idx, 2);
        idle(18); pulse(1, 0, 0); chk("t2_v12", fv(2), 12);
        idle(18); pulse(1, 0, 0); chk("t2_v13", fv(2), 13);
        chk("t2_f0", fv(0), INIT); chk("t2_f1", fv(1), INIT); chk("t2_f3", fv(3), INIT);

        // Accelerated edits on field 1
        idle(18); pulse(0, 0, 1); chk("t3_select", menu_state, 1);
        pulse(0, 1, 0); chk("t3_sel1", field_sel, 1);
        pulse(0, 0, 1); chk("t3_edit", menu_state, 2);
        pulse(1, 0, 0); chk("t3_v11", fv(1), 11);
        idle(1); pulse(1, 0, 0); chk("t3_v15", fv(1), 15);
        idle(1); pulse(1, 0, 0); chk("t3_v19", fv(1), 19);
        idle(1); pulse(1, 0, 0); chk("t3_v23", fv(1), 23);
        idle(1); pulse(0, 1, 0); chk("t3_v22", fv(1), 22);

        // Lower and upper saturation on field 0
        idle(18); pulse(0, 0, 1);
        pulse(0, 1, 0); chk("t4_sel0", field_sel, 0);
        pulse(0, 0, 1); chk("t4_edit", menu_state, 2);
        idle(2);
        s0 = strobes;
        for (int k = 0; k < 12; k++) begin
            idle(18); pulse(0, 1, 0);
            chk("t4_ccw", fv(0), (k < 10) ? 9 - k : 0);
        end
        idle(2);
        chk("t4_strobes", strobes - s0, 10);
        pulse(1, 0, 0); chk("t4_first_cw", fv(0), 1);
        for (int k = 0; k < 64; k++) begin
            idle(1); pulse(1, 0, 0);
        end
        chk("t4_v255", fv(0), 255);
        chk("t4_last_upd", update_valid, 1);
        idle(1); pulse(1, 0, 0);
        chk("t4_clamp_v", fv(0), 255); chk("t4_clamp_noupd", update_valid, 0);

        // Illegal both-direction pulse, button priority, inactivity timeout
        idle(1); pulse(1, 1, 0);
        chk("t5_both_v", fv(0), 255); chk("t5_both_state", menu_state, 2);
        pulse(1, 0, 1);
        chk("t5_btn_state", menu_state, 1); chk("t5_btn_v", fv(0), 255);
        idle(100); chk("t5_pre_timeout", menu_state, 1);
        idle(1); chk("t5_timeout", menu_state, 0);
        chk("t5_sel", field_sel, 0);
        chk("t5_f0", fv(0), 255); chk("t5_f1", fv(1), 22);
        chk("t5_f2", fv(2), 13); chk("t5_f3", fv(3), INIT);

        // Asynchronous reset mid-edit
        pulse(0, 0, 1); pulse(0, 1, 0); pulse(0, 0, 1);
        pulse(1, 0, 0);
        chk("t6_state", menu_state, 2); chk("t6_v11", fv(3), 11); chk("t6_upd", update_valid, 1);
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        chk("t6_rst_state", menu_state, 0);
        chk("t6_rst_sel", field_sel, 0);
        chk("t6_rst_upd", update_valid, 0);
        for (int i = 0; i < NF; i++) chk("t6_rst_field", fv(i), INIT);
        idle(2);
        rst = 1'b0;
        idle(3);
        chk("t6_post_state", menu_state, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
